bsearch_ctrl: RTL and testbench

- Sequencing controller for the Lab 4 task 2 search datapath.
- Runs a binary search for a target byte A over an external synchronous-read RAM of 2^ADDR_W words, sorted ascending.
- Drives the RAM address, compares returned data and reports the hit location and found/done status to the top level for HEX display.
- Start is a level input already synchronized at the top level; this block adds no synchronizer.

---
 rtl/bsearch_ctrl_pkg.sv | 19 +
 rtl/bsearch_ctrl_if.sv | 36 +++
 rtl/bsearch_ctrl.sv | 121 ++++++++++++
 tb/tb_bsearch_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bsearch_ctrl_pkg.sv
// lab4_pkg: shared types and default sizes for the Lab 4 binary-search
// controller.
//   bs_state_t   FSM state encoding for bsearch_ctrl
//   LAB4_DATA_W  default RAM word / target width
//   LAB4_ADDR_W  default RAM address width (2^ADDR_W words)
package lab4_pkg;

    localparam int LAB4_DATA_W = 8;
    localparam int LAB4_ADDR_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_WAIT,
        S_CMP,
        S_DONE
    } bs_state_t;

endpackage

// File: rtl/bsearch_ctrl_if.sv
// bsearch_ctrl_if: request, RAM read and status signals of the search
// controller.
//   start     level request, sampled in IDLE
//   A         search target, latched at search start
//   ram_q     RAM read data, one cycle after ram_addr is sampled
//   ram_addr  registered RAM read address
//   loc       address of the match (0 when not found)
//   found     target located
//   done      search finished, result valid
//   busy      search in progress
// slave modport is the controller side; master is the top level / RAM side.
interface bsearch_ctrl_if #(
    parameter int DATA_W = lab4_pkg::LAB4_DATA_W,
    parameter int ADDR_W = lab4_pkg::LAB4_ADDR_W
) ();

    logic              start;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] ram_q;
    logic [ADDR_W-1:0] ram_addr;
    logic [ADDR_W-1:0] loc;
    logic              found;
    logic              done;
    logic              busy;

    modport slave (
        input  start, A, ram_q,
        output ram_addr, loc, found, done, busy
    );

    modport master (
        output start, A, ram_q,
        input  ram_addr, loc, found, done, busy
    );

endinterface

// File: rtl/bsearch_ctrl.sv
// bsearch_ctrl: binary search for target A over an external sync-read RAM of
// 2^ADDR_W ascending-sorted words.
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    bsearch_ctrl_if.slave: start/A in, ram_q in, ram_addr out,
//          loc/found/done/busy status out
// Each probe takes three cycles (CALC -> WAIT -> CMP), so start sampled in
// cycle N yields done in cycle N+1+3k for k probes.
module bsearch_ctrl
    import lab4_pkg::*;
#(
    parameter int DATA_W = LAB4_DATA_W,
    parameter int ADDR_W = LAB4_ADDR_W
) (
    input  logic           clk,
    input  logic           reset,
    bsearch_ctrl_if.slave  bus
);

    // lo/hi carry one extra bit so hi = mid-1 at mid = 0 cannot alias to
    // the top address.
    localparam logic [ADDR_W:0] HI_INIT = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    bs_state_t         state;
    logic [ADDR_W:0]   lo, hi;
    logic [DATA_W-1:0] a_reg;
    logic [ADDR_W-1:0] ram_addr_q, loc_q;
    logic              found_q, done_q, busy_q;

    logic [ADDR_W+1:0] mid_sum;
    logic [ADDR_W-1:0] mid;
    logic [ADDR_W:0]   mid_ext;

    // lo/hi are stable from CALC through CMP, so mid is the same value that
    // was issued as ram_addr when the comparison happens.
    assign mid_sum = {1'b0, lo} + {1'b0, hi};
    assign mid     = mid_sum[ADDR_W:1];
    assign mid_ext = {1'b0, mid};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            ram_addr_q <= '0;
            loc_q      <= '0;
            found_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            lo         <= '0;
            hi         <= HI_INIT;
            a_reg      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_reg   <= bus.A;
                        lo      <= '0;
                        hi      <= HI_INIT;
                        found_q <= 1'b0;
                        done_q  <= 1'b0;
                        loc_q   <= '0;
                        busy_q  <= 1'b1;
                        state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    ram_addr_q <= mid;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // RAM samples ram_addr at the end of this cycle
                    state <= S_CMP;
                end
                S_CMP: begin
                    if (bus.ram_q == a_reg) begin
                        found_q <= 1'b1;
                        loc_q   <= mid;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= S_DONE;
                    end else if (bus.ram_q < a_reg) begin
                        // range exhausted on the high side
                        if (mid_ext == hi) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            lo    <= mid_ext + ONE;
                            state <= S_CALC;
                        end
                    end else begin
                        // range exhausted on the low side
                        if (mid_ext == lo) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            hi    <= mid_ext - ONE;
                            state <= S_CALC;
                        end
                    end
                end
                S_DONE: begin
                    // start must fall before another search can begin
                    if (!bus.start) begin
                        done_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ram_addr = ram_addr_q;
    assign bus.loc      = loc_q;
    assign bus.found    = found_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_bsearch_ctrl.sv
module tb_bsearch_ctrl;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int NW = 1 << AW;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [DW-1:0] mem [NW];

    bsearch_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    bsearch_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural synchronous-read RAM
    always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

    task automatic fill_linear();
        for (int i = 0; i < NW; i++) mem[i] = 8'(2 * i);
    endtask

    function automatic bit in_mem(input int a);
        for (int i = 0; i < NW; i++) if (int'(mem[i]) == a) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: textbook binary search on integers; returns probe count.
    function automatic int model_probes(input int a, output bit f, output int hit);
        int lo = 0, hi = NW - 1, mid, k = 0;
        f = 1'b0; hit = 0;
        for (int it = 0; it < 64; it++) begin
            mid = (lo + hi) / 2;
            k++;
            if (int'(mem[mid]) == a) begin f = 1'b1; hit = mid; return k; end
            if (int'(mem[mid]) < a) begin
                if (mid == hi) return k;
                lo = mid + 1;
            end else begin
                if (mid == lo) return k;
                hi = mid - 1;
            end
        end
        return k;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Start a search and watch until done. lat = cycles from start sample to
    // done (-1 on timeout). busy_ok clears if busy drops before done or
    // done and busy are ever seen together.
    task automatic do_search(input logic [DW-1:0] a, input bit hold,
                             input int chg_cyc, input logic [DW-1:0] a2,
                             output int lat, output bit busy_ok);
        bus.A = a; bus.start = 1'b1; lat = -1; busy_ok = 1'b1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            tick();
            if (!hold) bus.start = 1'b0;
            if (c == chg_cyc) bus.A = a2;
            if (bus.done && bus.busy) busy_ok = 1'b0;
            if (bus.done) lat = c;
            else if (!bus.busy) busy_ok = 1'b0;
        end
        if (!hold) tick();  // DONE -> IDLE
    endtask

    task automatic check_search(input string nm, input logic [DW-1:0] a,
                                input int lat, input bit busy_ok);
        bit f; int hit, k;
        k = model_probes(int'(a), f, hit);
        checks++; if (lat !== 1 + 3 * k) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, lat, 1 + 3 * k); end
        checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL %s busy: got %0b want 1", nm, busy_ok); end
        checks++; if (bus.found !== in_mem(int'(a))) begin errors++; $display("FAIL %s found: got %0b want %0b", nm, bus.found, in_mem(int'(a))); end
        if (in_mem(int'(a))) begin
            checks++; if (mem[bus.loc] !== a) begin errors++; $display("FAIL %s mem[loc]: loc=%0d holds %0d want %0d", nm, bus.loc, mem[bus.loc], a); end
        end else begin
            checks++; if (bus.loc !== '0) begin errors++; $display("FAIL %s loc: got %0d want 0", nm, bus.loc); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.start = 1'b0; bus.A = '0;
        #12;
        checks++; if ({bus.ram_addr, bus.loc, bus.found, bus.done, bus.busy} !== '0) begin
            errors++; $display("FAIL reset outputs: got addr=%0d loc=%0d f=%0b d=%0b b=%0b want all 0",
                               bus.ram_addr, bus.loc, bus.found, bus.done, bus.busy); end
        @(negedge clk); reset = 1'b0;
        tick();
    endtask

    task automatic test_first_probe();
        int lat; bit ok;
        do_search(8'd30, 1'b0, 0, 8'd0, lat, ok);
        checks++; if (lat !== 4) begin errors++; $display("FAIL hit30 latency: got %0d want 4", lat); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hit30 busy: got %0b want 1", ok); end
        checks++; if (bus.found !== 1'b1 || bus.loc !== 5'd15) begin errors++; $display("FAIL hit30 result: got f=%0b loc=%0d want f=1 loc=15", bus.found, bus.loc); end
    endtask

    task automatic test_boundaries();
        int lat; bit ok;
        do_search(8'd0, 1'b0, 0, 8'd0, lat, ok);
        check_search("a0", 8'd0, lat, ok);
        checks++; if (bus.loc !== 5'd0 || lat > 19) begin errors++; $display("FAIL a0 loc/lat: got loc=%0d lat=%0d want 0, <=19", bus.loc, lat); end
        do_search(8'd62, 1'b0, 0, 8'd0, lat, ok);
        check_search("a62", 8'd62, lat, ok);
        checks++; if (bus.loc !== 5'd31 || lat > 19) begin errors++; $display("FAIL a62 loc/lat: got loc=%0d lat=%0d want 31, <=19", bus.loc, lat); end
    endtask

    task automatic test_not_found();
        int lat; bit ok;
        do_search(8'd21, 1'b0, 0, 8'd0, lat, ok);
        check_search("a21", 8'd21, lat, ok);
        checks++; if (lat < 0 || lat > 19) begin errors++; $display("FAIL a21 bound: got %0d want <=19", lat); end
        do_search(8'd63, 1'b0, 0, 8'd0, lat, ok);
        check_search("a63", 8'd63, lat, ok);
        checks++; if (bus.found !== 1'b0 || bus.ram_addr !== 5'd31) begin errors++; $display("FAIL a63 last probe: got f=%0b addr=%0d want f=0 addr=31", bus.found, bus.ram_addr); end
    endtask

    task automatic test_hold_start();
        int lat; bit ok;
        do_search(8'd20, 1'b1, 0, 8'd0, lat, ok);
        check_search("hold20", 8'd20, lat, ok);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.ram_addr !== 5'd10) begin
                errors++; $display("FAIL hold retrigger: got d=%0b b=%0b addr=%0d want d=1 b=0 addr=10", bus.done, bus.busy, bus.ram_addr); end
        end
        bus.start = 1'b0;
        tick();
        checks++; if (bus.done !== 1'b0 || bus.found !== 1'b1 || bus.loc !== 5'd10) begin
            errors++; $display("FAIL hold release: got d=%0b f=%0b loc=%0d want d=0 f=1 loc=10", bus.done, bus.found, bus.loc); end
        do_search(8'd40, 1'b0, 0, 8'd0, lat, ok);
        check_search("a40", 8'd40, lat, ok);
        checks++; if (bus.loc !== 5'd20) begin errors++; $display("FAIL a40 loc: got %0d want 20", bus.loc); end
    endtask

    task automatic test_async_reset();
        int lat; bit ok;
        bus.A = 8'd44; bus.start = 1'b1;
        tick();                 // sampled -> CALC
        bus.start = 1'b0;
        tick();                 // -> WAIT, ram_addr = 15
        checks++; if (bus.busy !== 1'b1 || bus.ram_addr !== 5'd15) begin errors++; $display("FAIL pre-reset: got b=%0b addr=%0d want b=1 addr=15", bus.busy, bus.ram_addr); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({bus.ram_addr, bus.loc, bus.found, bus.done, bus.busy} !== '0) begin
            errors++; $display("FAIL async reset: got addr=%0d loc=%0d f=%0b d=%0b b=%0b want all 0",
                               bus.ram_addr, bus.loc, bus.found, bus.done, bus.busy); end
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL post-reset idle: got b=%0b d=%0b want 0 0", bus.busy, bus.done); end
        end
        do_search(8'd44, 1'b0, 0, 8'd0, lat, ok);
        check_search("a44", 8'd44, lat, ok);
        checks++; if (bus.loc !== 5'd22) begin errors++; $display("FAIL a44 loc: got %0d want 22", bus.loc); end
    endtask

    task automatic test_late_a();
        int lat; bit ok;
        do_search(8'd10, 1'b0, 2, 8'd50, lat, ok);
        check_search("lateA", 8'd10, lat, ok);
        checks++; if (bus.found !== 1'b1 || bus.loc !== 5'd5) begin errors++; $display("FAIL lateA result: got f=%0b loc=%0d want f=1 loc=5", bus.found, bus.loc); end
    endtask

    // random sorted contents with duplicates, mixed hit/miss targets
    task automatic test_random();
        int lat; bit ok; int v; logic [DW-1:0] a;
        for (int t = 0; t < 10; t++) begin
            v = int'($urandom_range(0, 10));
            for (int i = 0; i < NW; i++) begin
                mem[i] = 8'(v);
                v += int'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 1) a = mem[$urandom_range(0, NW - 1)];
            else a = 8'($urandom_range(0, 110));
            do_search(a, 1'b0, 0, 8'd0, lat, ok);
            check_search("random", a, lat, ok);
        end
        fill_linear();
    endtask

    initial begin
        fill_linear();
        test_reset();
        test_first_probe();
        test_boundaries();
        test_not_found();
        test_hold_start();
        test_async_reset();
        test_late_a();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
